// File: rtl/cnn_infer_ctrl_pkg.sv
// Shared definitions for the CNN frame sequencer.
//   state_e            : controller states (LOAD, DRAIN, START, WAIT, RESULT)
//   ERR_FRAMING/TIMEOUT: bit positions inside the 2-bit result error field
//   IMG_PIXELS_DEFAULT : 28x28 frame size
//   cls_width()        : class-index width, never narrower than one bit
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  localparam int ERR_FRAMING = 0;
  localparam int ERR_TIMEOUT = 1;

  localparam int IMG_PIXELS_DEFAULT = 784;

  function automatic int cls_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_infer_ctrl_if.sv
// Host-facing bus of the CNN frame sequencer: the pixel byte stream in and
// the classification result out, both valid/ready.
//   slave  : controller side (receives pixels, drives results)
//   master : host side (drives pixels, consumes results)
interface cnn_infer_ctrl_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 2
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic [DATA_WIDTH-1:0]                    s_pix_data;
  logic                                     s_pix_valid;
  logic                                     s_pix_last;
  logic                                     s_pix_ready;

  logic                                     m_res_valid;
  logic                                     m_res_ready;
  logic [CLS_W-1:0]                         m_res_class;
  logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0]   m_res_logits;
  logic [1:0]                               m_res_err;

  modport slave (
    input  s_pix_data, s_pix_valid, s_pix_last, m_res_ready,
    output s_pix_ready, m_res_valid, m_res_class, m_res_logits, m_res_err
  );

  modport master (
    output s_pix_data, s_pix_valid, s_pix_last, m_res_ready,
    input  s_pix_ready, m_res_valid, m_res_class, m_res_logits, m_res_err
  );

endinterface

// File: rtl/cnn_infer_ctrl_argmax.sv
// Combinational argmax over signed logits.
//   logits  : NUM_CLASSES two's-complement values, index 0 first
//   max_idx : index of the largest value; ties go to the lowest index
module cnn_argmax #(
  parameter int NUM_CLASSES = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int CLS_W       = 1
) (
  input  logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0] logits,
  output logic [CLS_W-1:0]                       max_idx
);

  logic signed [DATA_WIDTH-1:0] best;

  // Strict greater-than keeps the earliest index on a tie.
  always_comb begin
    best    = logits[0];
    max_idx = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if ($signed(logits[i]) > best) begin
        best    = logits[i];
        max_idx = CLS_W'(i);
      end
    end
  end

endmodule

// File: rtl/cnn_infer_ctrl.sv
// Frame-level sequencer for the single-image CNN pipeline.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   bus (slave)    : pixel stream in, result (class/logits/err) out
//   cnn_valid_in   : one-cycle start strobe to the pipeline
//   cnn_image      : assembled frame, written only while loading
//   cnn_valid_out  : pipeline completion strobe, cnn_logits valid with it
//   busy           : high in START/WAIT/RESULT
//   frame_count    : error-free results delivered, wraps
//
// state  | meaning
// LOAD   | accepting pixels into cnn_image
// DRAIN  | frame overran; discard beats until last
// START  | strobe cnn_valid_in for one cycle
// WAIT   | waiting for cnn_valid_out under the watchdog
// RESULT | presenting result until handshake
module cnn_infer_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int IMG_PIXELS     = IMG_PIXELS_DEFAULT,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CLASSES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CLS_W          = cls_width(NUM_CLASSES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  cnn_infer_ctrl_if.slave                        bus,
  output logic                                   cnn_valid_in,
  output logic [DATA_WIDTH-1:0]                  cnn_image [IMG_PIXELS],
  input  logic                                   cnn_valid_out,
  input  logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0] cnn_logits,
  output logic                                   busy,
  output logic [15:0]                            frame_count
);

  localparam logic [2:0] S_LOAD   = 3'(ST_LOAD);
  localparam logic [2:0] S_DRAIN  = 3'(ST_DRAIN);
  localparam logic [2:0] S_START  = 3'(ST_START);
  localparam logic [2:0] S_WAIT   = 3'(ST_WAIT);
  localparam logic [2:0] S_RESULT = 3'(ST_RESULT);

  localparam int IDX_W = $clog2(IMG_PIXELS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(IMG_PIXELS - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       ERR_FRM_V = 2'(1 << ERR_FRAMING);
  localparam logic [1:0]       ERR_TMO_V = 2'(1 << ERR_TIMEOUT);

  logic [2:0]                             state_q, state_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [WD_W-1:0]                        wdog_q, wdog_d;
  logic                                   res_valid_q, res_valid_d;
  logic [CLS_W-1:0]                       res_class_q, res_class_d;
  logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0] res_logits_q, res_logits_d;
  logic [1:0]                             res_err_q, res_err_d;
  logic [15:0]                            fcnt_q, fcnt_d;
  logic [DATA_WIDTH-1:0]                  img_q [IMG_PIXELS];
  logic                                   img_we;
  logic [CLS_W-1:0]                       amax_class;
  logic                                   pix_beat;

  cnn_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .DATA_WIDTH  (DATA_WIDTH),
    .CLS_W       (CLS_W)
  ) u_argmax (
    .logits  (cnn_logits),
    .max_idx (amax_class)
  );

  // Ready is masked during reset so no beat is taken in the reset cycle.
  assign bus.s_pix_ready  = !rst && (state_q == S_LOAD || state_q == S_DRAIN);
  assign pix_beat         = bus.s_pix_valid && bus.s_pix_ready;
  assign bus.m_res_valid  = res_valid_q;
  assign bus.m_res_class  = res_class_q;
  assign bus.m_res_logits = res_logits_q;
  assign bus.m_res_err    = res_err_q;
  assign cnn_valid_in     = (state_q == S_START);
  assign busy             = (state_q == S_START) || (state_q == S_WAIT) ||
                            (state_q == S_RESULT);
  assign frame_count      = fcnt_q;
  assign cnn_image        = img_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wdog_d       = wdog_q;
    res_valid_d  = res_valid_q;
    res_class_d  = res_class_q;
    res_logits_d = res_logits_q;
    res_err_d    = res_err_q;
    fcnt_d       = fcnt_q;
    img_we       = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (pix_beat) begin
          img_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (bus.s_pix_last) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_START;
            end else begin
              state_d      = S_RESULT;
              res_valid_d  = 1'b1;
              res_err_d    = ERR_FRM_V;
              res_class_d  = '0;
              res_logits_d = '0;
            end
          end else if (idx_q == IDX_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (pix_beat && bus.s_pix_last) begin
          state_d      = S_RESULT;
          res_valid_d  = 1'b1;
          res_err_d    = ERR_FRM_V;
          res_class_d  = '0;
          res_logits_d = '0;
        end
      end

      S_START: begin
        state_d = S_WAIT;
        wdog_d  = '0;
      end

      S_WAIT: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (cnn_valid_out) begin
          state_d      = S_RESULT;
          res_valid_d  = 1'b1;
          res_err_d    = 2'b00;
          res_class_d  = amax_class;
          res_logits_d = cnn_logits;
        end else if (wdog_q == WD_LAST) begin
          state_d      = S_RESULT;
          res_valid_d  = 1'b1;
          res_err_d    = ERR_TMO_V;
          res_class_d  = '0;
          res_logits_d = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_RESULT: begin
        if (res_valid_q && bus.m_res_ready) begin
          state_d     = S_LOAD;
          idx_d       = '0;
          res_valid_d = 1'b0;
          if (res_err_q == 2'b00) fcnt_d = fcnt_q + 1'b1;
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      idx_q        <= '0;
      wdog_q       <= '0;
      res_valid_q  <= 1'b0;
      res_class_q  <= '0;
      res_logits_q <= '0;
      res_err_q    <= '0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wdog_q       <= wdog_d;
      res_valid_q  <= res_valid_d;
      res_class_q  <= res_class_d;
      res_logits_q <= res_logits_d;
      res_err_q    <= res_err_d;
      fcnt_q       <= fcnt_d;
    end
  end

  // Frame store kept apart from the control flops: write-enabled by index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IMG_PIXELS; i++) img_q[i] <= '0;
    end else if (img_we) begin
      img_q[idx_q] <= bus.s_pix_data;
    end
  end

endmodule

// File: tb/tb_cnn_infer_ctrl.sv
`timescale 1ns/1ps
module tb_cnn_infer_ctrl;
  localparam int IMG = 784;
  localparam int DW  = 8;
  localparam int NC  = 2;
  localparam int T   = 4096;

  typedef logic [0:NC-1][DW-1:0] lg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cnn_valid_in;
  logic [DW-1:0] cnn_image [IMG];
  logic          cnn_valid_out = 1'b0;
  lg_t           cnn_logits = '0;
  logic          busy;
  logic [15:0]   frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int vin_cnt = 0;
  int fc_exp = 0;
  logic [DW-1:0] exp_img [IMG];

  cnn_infer_ctrl_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) bus ();

  cnn_infer_ctrl #(
    .IMG_PIXELS(IMG), .DATA_WIDTH(DW), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnn_valid_in(cnn_valid_in),
    .cnn_image(cnn_image), .cnn_valid_out(cnn_valid_out),
    .cnn_logits(cnn_logits), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cnn_valid_in === 1'b1) vin_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Reference argmax: find the maximum signed value, then its first index.
  function automatic int exp_class(input lg_t lg);
    int mx = -1000;
    int k = 0;
    for (int i = 0; i < NC; i++) if (int'($signed(lg[i])) > mx) mx = int'($signed(lg[i]));
    for (int i = NC - 1; i >= 0; i--) if (int'($signed(lg[i])) == mx) k = i;
    return k;
  endfunction

  function automatic int img_diff();
    int bad = 0;
    for (int i = 0; i < IMG; i++) if (cnn_image[i] !== exp_img[i]) bad++;
    return bad;
  endfunction

  function automatic lg_t rand_lg();
    logic [31:0] r;
    r = $urandom;
    return r[15:0];
  endfunction

  // Stimulus only: streams nbeats pixels, last on the final one.
  task automatic send_frame(input int nbeats, input bit ramp);
    logic [31:0] r;
    logic [DW-1:0] d;
    int guard;
    @(posedge clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.s_pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      r = $urandom;
      d = ramp ? i[7:0] : r[7:0];
      if (i < IMG) exp_img[i] = d;
      bus.s_pix_data  = d;
      bus.s_pix_valid = 1'b1;
      bus.s_pix_last  = (i == nbeats - 1);
      guard = 0;
      @(negedge clk);
      while (bus.s_pix_ready !== 1'b1 && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 100) begin
        n_cmp++; n_err++;
        $display("FAIL pix_ready_wait: beat %0d never accepted", i);
      end
      @(posedge clk); #1;
      bus.s_pix_valid = 1'b0;
      bus.s_pix_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.s_pix_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.s_pix_ready); end
    n_cmp++; if (bus.m_res_valid !== 1'b0 || bus.m_res_err !== 2'b00 || bus.m_res_logits !== '0) begin n_err++; $display("FAIL rst_res: valid %b err %b logits %h want 0", bus.m_res_valid, bus.m_res_err, bus.m_res_logits); end
    n_cmp++; if (busy !== 1'b0 || cnn_valid_in !== 1'b0) begin n_err++; $display("FAIL rst_busy: busy %b vin %b want 0", busy, cnn_valid_in); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rst_fcnt: got %0d want 0", frame_count); end
    n_cmp++; if (img_diff() != 0) begin n_err++; $display("FAIL rst_image: %0d pixels nonzero", img_diff()); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.s_pix_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", bus.s_pix_ready); end
  endtask

  // Full-length frame, pipeline answers after 'delay' WAIT cycles,
  // consumer holds ready low for 'hold' cycles.
  task automatic test_full_frame(input bit ramp, input lg_t lg, input int delay, input int hold);
    int v0, ec;
    lg_t r;
    v0 = vin_cnt;
    ec = exp_class(lg);
    send_frame(IMG, ramp);
    @(negedge clk);
    n_cmp++; if (cnn_valid_in !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL start_latency: vin %b busy %b want 1 1", cnn_valid_in, busy); end
    n_cmp++; if (img_diff() != 0) begin n_err++; $display("FAIL image: %0d pixels differ", img_diff()); end
    @(posedge clk); #1;
    if (delay > 0) begin repeat (delay) @(posedge clk); #1; end
    n_cmp++; if (bus.m_res_valid !== 1'b0 || bus.s_pix_ready !== 1'b0) begin n_err++; $display("FAIL wait_state: res_valid %b ready %b want 0 0", bus.m_res_valid, bus.s_pix_ready); end
    cnn_valid_out = 1'b1;
    cnn_logits    = lg;
    @(posedge clk); #1;
    cnn_valid_out = 1'b0;
    r = rand_lg();
    cnn_logits = r;
    @(negedge clk);
    n_cmp++; if (bus.m_res_valid !== 1'b1 || bus.m_res_err !== 2'b00) begin n_err++; $display("FAIL res_valid: valid %b err %b want 1 00", bus.m_res_valid, bus.m_res_err); end
    n_cmp++; if (bus.m_res_class !== 1'(ec)) begin n_err++; $display("FAIL res_class: logits %h got %0d want %0d", lg, bus.m_res_class, ec); end
    n_cmp++; if (bus.m_res_logits !== lg) begin n_err++; $display("FAIL res_logits: got %h want %h", bus.m_res_logits, lg); end
    for (int c = 0; c < hold; c++) begin
      if (c == 3) bus.s_pix_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.m_res_valid !== 1'b1 || bus.m_res_class !== 1'(ec) || bus.m_res_logits !== lg ||
          bus.m_res_err !== 2'b00 || bus.s_pix_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL hold_stable: cyc %0d valid %b class %0d logits %h err %b ready %b busy %b", c,
                 bus.m_res_valid, bus.m_res_class, bus.m_res_logits, bus.m_res_err, bus.s_pix_ready, busy);
      end
    end
    bus.s_pix_valid = 1'b0;
    @(posedge clk); #1; bus.m_res_ready = 1'b1;
    @(posedge clk); #1; bus.m_res_ready = 1'b0;
    fc_exp++;
    @(negedge clk);
    n_cmp++; if (bus.m_res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL after_hs: valid %b busy %b want 0 0", bus.m_res_valid, busy); end
    n_cmp++; if (frame_count !== 16'(fc_exp)) begin n_err++; $display("FAIL fcnt: got %0d want %0d", frame_count, fc_exp); end
    n_cmp++; if (vin_cnt - v0 != 1) begin n_err++; $display("FAIL vin_pulses: got %0d want 1", vin_cnt - v0); end
  endtask

  task automatic test_nominal();
    test_full_frame(1'b1, {8'hFB, 8'h0C}, 20, 0);
    n_cmp++; if (cnn_image[783] !== 8'h0F) begin n_err++; $display("FAIL img_783: got %h want 0f", cnn_image[783]); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL nominal_fcnt: got %0d want 1", frame_count); end
  endtask

  // Frame that ends early (short) or overruns into DRAIN (long).
  task automatic test_framing(input int nbeats);
    int v0;
    v0 = vin_cnt;
    send_frame(nbeats, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.m_res_valid !== 1'b1 || bus.m_res_err !== 2'b01) begin n_err++; $display("FAIL frm_err(%0d): valid %b err %b want 1 01", nbeats, bus.m_res_valid, bus.m_res_err); end
    n_cmp++; if (bus.m_res_class !== 1'b0 || bus.m_res_logits !== '0) begin n_err++; $display("FAIL frm_res(%0d): class %0d logits %h want 0", nbeats, bus.m_res_class, bus.m_res_logits); end
    n_cmp++; if (img_diff() != 0) begin n_err++; $display("FAIL frm_image(%0d): %0d pixels differ", nbeats, img_diff()); end
    @(posedge clk); #1; bus.m_res_ready = 1'b1;
    @(posedge clk); #1; bus.m_res_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (frame_count !== 16'(fc_exp) || bus.m_res_valid !== 1'b0) begin n_err++; $display("FAIL frm_fcnt(%0d): fcnt %0d valid %b want %0d 0", nbeats, frame_count, bus.m_res_valid, fc_exp); end
    n_cmp++; if (vin_cnt != v0) begin n_err++; $display("FAIL frm_vin(%0d): got %0d pulses want 0", nbeats, vin_cnt - v0); end
  endtask

  task automatic test_timeout();
    int n;
    lg_t lg;
    send_frame(IMG, 1'b0);
    @(negedge clk);
    n_cmp++; if (cnn_valid_in !== 1'b1) begin n_err++; $display("FAIL tmo_start: got %b want 1", cnn_valid_in); end
    n = 0;
    while (n < 2 * T) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.m_res_valid === 1'b1) break;
    end
    // START cycle plus TIMEOUT_CYCLES cycles in WAIT.
    n_cmp++; if (n != T + 1) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", n, T + 1); end
    n_cmp++; if (bus.m_res_err !== 2'b10 || bus.m_res_logits !== '0 || bus.m_res_class !== 1'b0) begin n_err++; $display("FAIL tmo_res: err %b logits %h class %0d want 10 0 0", bus.m_res_err, bus.m_res_logits, bus.m_res_class); end
    lg = 16'h7F01;
    @(posedge clk); #1; cnn_valid_out = 1'b1; cnn_logits = lg;
    @(posedge clk); #1; cnn_valid_out = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_res_valid !== 1'b1 || bus.m_res_err !== 2'b10 || bus.m_res_logits !== '0) begin n_err++; $display("FAIL tmo_late: valid %b err %b logits %h want 1 10 0", bus.m_res_valid, bus.m_res_err, bus.m_res_logits); end
    @(posedge clk); #1; bus.m_res_ready = 1'b1;
    @(posedge clk); #1; bus.m_res_ready = 1'b0; cnn_valid_out = 1'b1;
    @(posedge clk); #1; cnn_valid_out = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus.m_res_valid !== 1'b0 || bus.s_pix_ready !== 1'b1) begin n_err++; $display("FAIL tmo_idle: busy %b valid %b ready %b want 0 0 1", busy, bus.m_res_valid, bus.s_pix_ready); end
    n_cmp++; if (frame_count !== 16'(fc_exp)) begin n_err++; $display("FAIL tmo_fcnt: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_reset_wait();
    lg_t lg;
    send_frame(IMG, 1'b0);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < IMG; i++) exp_img[i] = '0;
    fc_exp = 0;
    @(negedge clk);
    n_cmp++; if (bus.m_res_valid !== 1'b0 || bus.m_res_class !== 1'b0 || bus.m_res_logits !== '0 || bus.m_res_err !== 2'b00) begin n_err++; $display("FAIL rstw_res: valid %b class %0d logits %h err %b want 0", bus.m_res_valid, bus.m_res_class, bus.m_res_logits, bus.m_res_err); end
    n_cmp++; if (busy !== 1'b0 || cnn_valid_in !== 1'b0 || frame_count !== 16'd0) begin n_err++; $display("FAIL rstw_ctl: busy %b vin %b fcnt %0d want 0", busy, cnn_valid_in, frame_count); end
    n_cmp++; if (bus.s_pix_ready !== 1'b1) begin n_err++; $display("FAIL rstw_load: ready %b want 1", bus.s_pix_ready); end
    n_cmp++; if (img_diff() != 0) begin n_err++; $display("FAIL rstw_image: %0d pixels nonzero", img_diff()); end
    lg = rand_lg();
    @(posedge clk); #1; cnn_valid_out = 1'b1; cnn_logits = lg;
    @(posedge clk); #1; cnn_valid_out = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstw_late: valid %b busy %b want 0 0", bus.m_res_valid, busy); end
    test_full_frame(1'b0, rand_lg(), $urandom_range(0, 40), 0);
  endtask

  initial begin
    bus.s_pix_data  = '0;
    bus.s_pix_valid = 1'b0;
    bus.s_pix_last  = 1'b0;
    bus.m_res_ready = 1'b0;
    for (int i = 0; i < IMG; i++) exp_img[i] = '0;

    test_reset();
    test_nominal();
    test_framing(100);
    test_framing(800);
    test_full_frame(1'b0, rand_lg(), $urandom_range(0, 40), $urandom_range(0, 3));
    test_timeout();
    test_full_frame(1'b0, {8'h80, 8'h80}, $urandom_range(0, 40), 0);
    test_full_frame(1'b0, {8'h7F, 8'h80}, $urandom_range(0, 40), 0);
    test_full_frame(1'b0, {8'h80, 8'h00}, $urandom_range(0, 40), 0);
    for (int k = 0; k < 3; k++) test_full_frame(1'b0, rand_lg(), $urandom_range(0, 60), $urandom_range(0, 3));
    test_full_frame(1'b0, rand_lg(), T - 1, 0);
    test_full_frame(1'b0, rand_lg(), $urandom_range(0, 40), 10);
    test_reset_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_infer_ctrl.md
Name: cnn_infer_ctrl

Overview:
Frame-level sequencer for the single-image CNN pipeline (conv → relu → maxpool → dense → dense).
- Accepts a 28x28 image as a byte stream over valid/ready with last, and assembles it into the flat image array the pipeline consumes.
- Fires the pipeline's one-cycle start strobe, waits for its completion strobe under a watchdog, then captures the logits.
- Returns the argmax class plus error flags over a valid/ready result interface.

Parameters:
IMG_PIXELS, 784, pixels per frame (28x28)
DATA_WIDTH, 8, pixel and logit width
NUM_CLASSES, 2, logits produced by the pipeline
TIMEOUT_CYCLES, 4096, max cycles in WAIT before the watchdog fires
CLS_W, $clog2(NUM_CLASSES) min 1, class index width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
s_pix_data  in  DATA_WIDTH  pixel byte, row-major
s_pix_valid  in  1  pixel beat valid
s_pix_last  in  1  marks final beat of a frame
s_pix_ready  out  1  beat accepted when valid&&ready
cnn_valid_in  out  1  one-cycle start strobe to pipeline
cnn_image  out  DATA_WIDTH x [0:IMG_PIXELS-1]  assembled frame to pipeline
cnn_valid_out  in  1  pipeline completion strobe
cnn_logits  in  DATA_WIDTH x [0:NUM_CLASSES-1]  pipeline logits, valid with cnn_valid_out
m_res_valid  out  1  result valid
m_res_ready  in  1  result consumer ready
m_res_class  out  CLS_W  argmax class
m_res_logits  out  DATA_WIDTH x [0:NUM_CLASSES-1]  captured logits
m_res_err  out  2  bit0 framing error, bit1 timeout
busy  out  1  high in START/WAIT/RESULT
frame_count  out  16  count of error-free results delivered, wraps

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - State → LOAD, pixel index 0, watchdog 0.
  - All outputs 0: cnn_image all zeros, s_pix_ready 0 for the reset cycle, m_res_* 0, busy 0, frame_count 0.
  - Reset mid-frame discards the partial frame. Reset during WAIT abandons the in-flight inference; a later cnn_valid_out is ignored because it arrives outside WAIT.
- States: LOAD, DRAIN, START, WAIT, RESULT.
- LOAD:
  - s_pix_ready=1. Each accepted beat writes cnn_image[idx] and increments idx.
  - last on beat idx==IMG_PIXELS-1 → START.
  - last on beat idx<IMG_PIXELS-1 → RESULT, err=01, class 0, logits 0.
  - Beat idx==IMG_PIXELS-1 without last → DRAIN.
- DRAIN:
  - s_pix_ready=1; beats are discarded.
  - Accepted last → RESULT, err=01.
- START:
  - cnn_valid_in=1 for exactly one cycle; s_pix_ready=0; → WAIT with watchdog cleared.
  - Latency: the cycle after the last beat is accepted.
- WAIT:
  - s_pix_ready=0. cnn_image is held stable; it is written only in LOAD.
  - cnn_valid_out=1 → capture cnn_logits, compute argmax, err=00, → RESULT.
  - Otherwise the watchdog increments. At TIMEOUT_CYCLES-1 without cnn_valid_out → RESULT, err=10, logits 0, class 0.
  - If cnn_valid_out and the watchdog limit coincide, cnn_valid_out wins.
- RESULT:
  - m_res_valid=1. m_res_* are registered and stable until the handshake.
  - On m_res_valid&&m_res_ready: → LOAD, idx=0. frame_count increments only if err==00.
  - m_res_valid deasserts the cycle after the handshake.
- Argmax:
  - Logits are signed two's complement.
  - Strict greater-than scan from index 0, so ties resolve to the lowest index.
  - Registered into m_res_class on the capture edge: m_res_valid rises 1 cycle after cnn_valid_out.
- cnn_valid_out outside WAIT is ignored with no state change.
- busy = state ∈ {START, WAIT, RESULT}.

Decomposition:
- Package cnn_ctrl_pkg:
  - state enum (LOAD, DRAIN, START, WAIT, RESULT).
  - ERR_FRAMING=0 and ERR_TIMEOUT=1 bit positions.
  - IMG_PIXELS_DEFAULT=784.
- One sub-module, cnn_argmax:
  - Combinational, parameterised NUM_CLASSES/DATA_WIDTH.
  - Signed compare, lowest-index tie-break.
  - Instantiated once in the controller; its output is registered there.

Test Plan:
1. Nominal frame: 784 beats, pixel i = i[7:0], last on beat 783; model returns logits {-5, 12} after 20 cycles → cnn_valid_in pulses once the cycle after beat 783; cnn_image[783]=0x0F; m_res_class=1, err=00; frame_count=1 after handshake.
2. Short frame: last on beat 99 → m_res_err=01, class 0; cnn_valid_in never asserted; frame_count unchanged.
3. Long frame: 800 beats, last on beat 799 → DRAIN absorbs beats 784-799; err=01; next frame processes normally.
4. Timeout: model never responds → m_res_valid rises TIMEOUT_CYCLES cycles after START with err=10, logits 0; a late cnn_valid_out is ignored.
5. Tie and signed edge: logits {0x80 (-128), 0x80} → class 0; logits {0x7F, 0x80} → class 0; logits {0x80, 0x00} → class 1.
6. Backpressure and reset:
   - m_res_ready low for 10 cycles → outputs held stable, s_pix_ready=0.
   - rst asserted mid-WAIT → all outputs 0 next cycle, state LOAD, subsequent frame correct.
